psram_opi_rsp: RTL and testbench
================================

Name: psram_opi_rsp

Overview:
- Synthesizable OPI DDR PSRAM target. It is the responder end of the psram_if bus that the PSRAM controller drives.
- Decodes CE#/SCK/IO command, address and latency phases, then:
  - stores write bytes into an internal byte array, honouring the DQS data mask;
  - returns read bytes with a DQS strobe.
- Used as the device model in the controller's bench and in FPGA loopback builds.
- Oversampled design: all bus pins are sampled on clk_i, which must run ≥4× SCK.

Parameters:
- MEM_BYTES, 4096: internal array size in bytes; address index = addr mod MEM_BYTES (power of 2).
- WCMD, 8'hA0: sync write opcode.
- RCMD, 8'h20: sync read opcode.
- MRW_CMD, 8'hC0: mode-register write opcode.
- MRR_CMD, 8'h40: mode-register read opcode.
- RST_LC, 5: reset value of both latency counts, in SCK cycles.

Ports:
- clk_i  in  1  system/oversample clock
- rst_i  in  1  synchronous reset, active-high
- psram_sck_i  in  1  bus clock from controller
- psram_ce_i  in  1  chip enable, active-low
- psram_io_i  in  8  IO from controller
- psram_io_o  out  8  IO to controller
- psram_io_en_o  out  1  IO output enable (1 = drive)
- psram_dqs_i  in  1  write data mask from controller (1 = masked byte)
- psram_dqs_o  out  1  read strobe
- psram_dqs_en_o  out  1  DQS output enable
- busy_o  out  1  CE asserted and FSM not IDLE
- err_o  out  1  sticky: illegal or mismatched opcode seen; cleared only by rst_i

Behaviour:
- Reset values:
  - outputs io_o=0, io_en_o=0, dqs_o=0, dqs_en_o=0, busy_o=0, err_o=0;
  - internal state rlc=wlc=RST_LC, FSM=IDLE;
  - array contents not reset.
- Input sampling:
  - sck, ce, io, dqs each pass through one register stage (s1) and are compared with a second stage (s2);
  - rise = s1&~s2, fall = ~s1&s2 on the sampled SCK;
  - every SCK edge (rise or fall) is one "beat" carrying one byte.
- Byte order and width rules:
  - Address: 32 bits, MSB byte first; it auto-increments by 1 per data beat.
  - Index: addr[log2(MEM_BYTES)-1:0], which wraps naturally at MEM_BYTES.
- FSM states:
  - IDLE: on ce falling → CMD.
  - CMD:
    - rise beat latches opcode;
    - fall beat must equal the latched opcode, else set err_o → DROP;
    - a matching pair → ADDR;
    - an opcode not in {WCMD, RCMD, MRW_CMD, MRR_CMD} → err_o, DROP.
  - ADDR: 4 beats → addr; then:
    - MRW → MRWD;
    - WCMD → LAT with count wlc;
    - RCMD/MRR → LAT with count rlc.
  - LAT:
    - counts rising edges down from the loaded value;
    - count 0 at entry, or reaching 0 → WDATA (write) or RDATA (read/MRR).
  - WDATA:
    - each beat writes io byte to mem[index] unless dqs sample = 1;
    - addr++ regardless of mask.
  - RDATA:
    - io_en_o=1 and dqs_en_o=1 from LAT exit until CE deasserts;
    - on each beat, within 1 clk_i of the edge detect, drive io_o = mem[index] (MRR: selected MR value) and dqs_o = sampled sck level;
    - addr++ per beat.
  - MRWD: the first beat writes the MR: addr[7:0]=0 → rlc=io[4:0]; addr[7:0]=4 → wlc=io[4:0]; other addresses are ignored. Then → DROP.
  - MRR values: addr[7:0]=0 → {3'b0,rlc}; 4 → {3'b0,wlc}; else 0.
  - DROP: ignore all beats until CE deasserts.
- CE deassert (sampled ce rising) in any state:
  - next clk_i FSM=IDLE, io_en_o=0, dqs_en_o=0, dqs_o=0;
  - a write in progress keeps bytes already committed; a partial command is discarded.
- Simultaneous CE rise and SCK edge: CE wins, the beat is discarded.
- rst_i mid-transaction → immediate return to reset values; the next transaction starts only after CE is seen high then low.

Optional Feature:
- Macro PSRAM_OPI_RSP_PAGE_WRAP_EN.
- Defined: data-phase address increment wraps within a 1024-byte page (addr[9:0] increments, addr[31:10] held), matching the device's row-boundary behaviour.
- Undefined: linear increment, wrapping only at MEM_BYTES.

Test Plan:
1. Reset, CE high, SCK idle → all outputs 0, busy_o=0.
2. Write 0xA0, addr 0x0000_0010, wlc=5, data 11 22 33 44 with DQS mask on beat 2 → mem[0x10]=11, mem[0x11]=22, mem[0x12] unchanged, mem[0x13]=44.
3. Read 0x20, addr 0x10, rlc=5 → after 5 SCK latency cycles, io_o = 11 22 xx 44 with dqs_o toggling in phase with SCK; io_en_o drops 1 clk_i after CE rises.
4. MRW addr 0 data 0x07, then MRR addr 0 → read byte 0x07; the following read waits 7 SCK cycles.
5. Opcode rise 0xA0 / fall 0xA1 → err_o=1 and sticky, mem untouched, FSM IDLE after CE high; opcode 0x55 → err_o=1.
6. Read starting at addr MEM_BYTES-2 for 4 beats → indices FFE, FFF, 000, 001. With PAGE_WRAP_EN, read from 0x3FE for 4 beats → 0x3FE, 0x3FF, 0x000, 0x001. CE raised during ADDR → FSM returns to IDLE, no write occurs.

Source files
------------

// File: rtl/psram_opi_rsp.sv
// OPI DDR PSRAM responder: oversamples the controller's CE#/SCK/IO/DQS on clk_i and serves sync read/write and MR access.
// Optional PSRAM_OPI_RSP_PAGE_WRAP_EN: data-phase address wraps inside a 1024-byte page.
module psram_opi_rsp #(
  parameter int         MEM_BYTES = 4096,
  parameter logic [7:0] WCMD      = 8'hA0,
  parameter logic [7:0] RCMD      = 8'h20,
  parameter logic [7:0] MRW_CMD   = 8'hC0,
  parameter logic [7:0] MRR_CMD   = 8'h40,
  parameter logic [4:0] RST_LC    = 5'd5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_i,
  output logic [7:0] psram_io_o,
  output logic       psram_io_en_o,
  input  logic       psram_dqs_i,
  output logic       psram_dqs_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = $clog2(MEM_BYTES);

  // IDLE wait CE# fall | CMD opcode pair | ADDR 4 beats | LAT rise countdown
  // WDATA/RDATA data beats | MRWD one MR byte | DROP ignore until CE# rise
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LAT, S_WDATA, S_RDATA, S_MRWD, S_DROP
  } state_t;

  state_t      state, state_n;
  logic        sck_s1, sck_s2, ce_s1, ce_s2, dqs_s1;
  logic [7:0]  io_s1;
  logic [7:0]  op_q;
  logic        op_valid;
  logic [31:0] addr;
  logic [1:0]  abeat;
  logic [4:0]  lat_cnt, rlc, wlc;
  logic [7:0]  rd_byte;
  logic        err_set;
  logic [7:0]  mem [MEM_BYTES];

  wire rise    = sck_s1 & ~sck_s2;
  wire fall    = ~sck_s1 & sck_s2;
  wire beat    = rise | fall;
  wire ce_rise = ce_s1 & ~ce_s2;
  wire ce_fall = ~ce_s1 & ce_s2;
  wire [AW-1:0] idx = addr[AW-1:0];

  function automatic logic [31:0] addr_inc(input logic [31:0] a);
`ifdef PSRAM_OPI_RSP_PAGE_WRAP_EN
    return {a[31:10], a[9:0] + 10'd1};
`else
    return a + 32'd1;
`endif
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    if (ce_rise) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ce_fall) state_n = S_CMD;
        S_CMD: begin
          if (fall && op_valid) begin
            if (io_s1 != op_q || !(op_q inside {WCMD, RCMD, MRW_CMD, MRR_CMD})) begin
              err_set = 1'b1;
              state_n = S_DROP;
            end else begin
              state_n = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (beat && abeat == 2'd3) begin
            if (op_q == MRW_CMD)   state_n = S_MRWD;
            else if (op_q == WCMD) state_n = (wlc == 5'd0) ? S_WDATA : S_LAT;
            else                   state_n = (rlc == 5'd0) ? S_RDATA : S_LAT;
          end
        end
        S_LAT: begin
          if (rise && lat_cnt <= 5'd1) state_n = (op_q == WCMD) ? S_WDATA : S_RDATA;
        end
        S_MRWD:  if (beat) state_n = S_DROP;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    rd_byte = mem[idx];
    if (op_q == MRR_CMD) begin
      case (addr[7:0])
        8'd0:    rd_byte = {3'b0, rlc};
        8'd4:    rd_byte = {3'b0, wlc};
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // CE# samples start low so a fresh transaction needs CE# seen high first
      sck_s1         <= 1'b0;
      sck_s2         <= 1'b0;
      ce_s1          <= 1'b0;
      ce_s2          <= 1'b0;
      io_s1          <= 8'h00;
      dqs_s1         <= 1'b0;
      op_q           <= 8'h00;
      op_valid       <= 1'b0;
      addr           <= 32'h0;
      abeat          <= 2'd0;
      lat_cnt        <= 5'd0;
      rlc            <= RST_LC;
      wlc            <= RST_LC;
      psram_io_o     <= 8'h00;
      psram_io_en_o  <= 1'b0;
      psram_dqs_o    <= 1'b0;
      psram_dqs_en_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      sck_s1 <= psram_sck_i;
      sck_s2 <= sck_s1;
      ce_s1  <= psram_ce_i;
      ce_s2  <= ce_s1;
      io_s1  <= psram_io_i;
      dqs_s1 <= psram_dqs_i;
      if (err_set) err_o <= 1'b1;
      if (ce_rise) begin
        psram_io_en_o  <= 1'b0;
        psram_dqs_en_o <= 1'b0;
        psram_dqs_o    <= 1'b0;
        op_valid       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            op_valid <= 1'b0;
            abeat    <= 2'd0;
          end
          S_CMD: begin
            if (rise) begin
              op_q     <= io_s1;
              op_valid <= 1'b1;
            end
          end
          S_ADDR: begin
            if (beat) begin
              addr    <= {addr[23:0], io_s1};
              abeat   <= abeat + 2'd1;
              lat_cnt <= (op_q == WCMD) ? wlc : rlc;
            end
          end
          S_LAT:   if (rise) lat_cnt <= lat_cnt - 5'd1;
          S_WDATA: if (beat) addr <= addr_inc(addr);
          S_RDATA: begin
            if (beat) begin
              psram_io_o  <= rd_byte;
              psram_dqs_o <= sck_s1;
              addr        <= addr_inc(addr);
            end
          end
          S_MRWD: begin
            if (beat) begin
              if (addr[7:0] == 8'd0)      rlc <= io_s1[4:0];
              else if (addr[7:0] == 8'd4) wlc <= io_s1[4:0];
            end
          end
          default: ;
        endcase
        if (state != S_RDATA && state_n == S_RDATA) begin
          psram_io_en_o  <= 1'b1;
          psram_dqs_en_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !ce_rise && state == S_WDATA && beat && !dqs_s1)
      mem[idx] <= io_s1;
  end

  assign busy_o = ~ce_s1 & (state != S_IDLE);

endmodule

// File: tb/tb_psram_opi_rsp.sv
// Directed bench for psram_opi_rsp: drives CE#/SCK/IO beats at 8x oversampling and checks with immediate assertions.
module tb_psram_opi_rsp;
  logic       clk = 1'b0;
  logic       rst, sck, ce, dqs;
  logic [7:0] io;
  logic [7:0] io_o;
  logic       io_en, dqs_o, dqs_en, busy, err;
  int         tests = 0;
  int         fails = 0;

`ifdef PSRAM_OPI_RSP_PAGE_WRAP_EN
  localparam logic [31:0] WRAP_NEXT = 32'h0000_0C00;
`else
  localparam logic [31:0] WRAP_NEXT = 32'h0000_0000;
`endif

  psram_opi_rsp dut (
    .clk_i(clk), .rst_i(rst), .psram_sck_i(sck), .psram_ce_i(ce),
    .psram_io_i(io), .psram_io_o(io_o), .psram_io_en_o(io_en),
    .psram_dqs_i(dqs), .psram_dqs_o(dqs_o), .psram_dqs_en_o(dqs_en),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK edge carrying byte d with mask m; returns after the DUT has acted on it.
  task automatic beat(input logic [7:0] d, input logic m);
    io  = d;
    dqs = m;
    wait_clk(2);
    sck = ~sck;
    wait_clk(2);
  endtask

  task automatic start_txn();
    ce = 1'b0;
    wait_clk(4);
  endtask

  task automatic end_txn();
    ce = 1'b1;
    wait_clk(4);
    sck = 1'b0;
    io  = 8'h00;
    dqs = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_head(input logic [7:0] op_r, input logic [7:0] op_f, input logic [31:0] a);
    beat(op_r, 1'b0);
    beat(op_f, 1'b0);
    for (int i = 0; i < 4; i++) beat(a[31-8*i -: 8], 1'b0);
  endtask

  task automatic do_write(input logic [7:0] op_r, input logic [7:0] op_f, input logic [31:0] a,
                          input int lat, input int n, input logic [31:0] d, input logic [3:0] m);
    start_txn();
    send_head(op_r, op_f, a);
    for (int i = 0; i < 2*lat-1; i++) beat(8'h00, 1'b0);
    for (int i = 0; i < n; i++) beat(d[31-8*i -: 8], m[i]);
    end_txn();
  endtask

  task automatic do_read(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input int lat, input int n, input logic [31:0] e);
    start_txn();
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    send_head(op, op, a);
    for (int i = 0; i < 2*lat-1; i++) begin
      if (i == 2*lat-2) chk({tag, "_en_before_last_lat"}, {31'b0, io_en}, 32'd0);
      beat(8'h00, 1'b0);
    end
    chk({tag, "_io_en"}, {31'b0, io_en}, 32'd1);
    chk({tag, "_dqs_en"}, {31'b0, dqs_en}, 32'd1);
    for (int i = 0; i < n; i++) begin
      beat(8'h00, 1'b0);
      chk($sformatf("%s_byte%0d", tag, i), {24'b0, io_o}, {24'b0, e[31-8*i -: 8]});
      chk($sformatf("%s_dqs%0d", tag, i), {31'b0, dqs_o}, {31'b0, sck});
    end
    ce = 1'b1;
    wait_clk(1);
    chk({tag, "_en_hold"}, {31'b0, io_en}, 32'd1);
    wait_clk(1);
    chk({tag, "_en_drop"}, {31'b0, io_en}, 32'd0);
    chk({tag, "_dqs_en_drop"}, {31'b0, dqs_en}, 32'd0);
    chk({tag, "_dqs_drop"}, {31'b0, dqs_o}, 32'd0);
    wait_clk(2);
    sck = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; sck = 1'b0; io = 8'h00; dqs = 1'b0;
    wait_clk(4);
    chk("rst_io", {24'b0, io_o}, 32'h0);
    chk("rst_io_en", {31'b0, io_en}, 32'd0);
    chk("rst_dqs", {31'b0, dqs_o}, 32'd0);
    chk("rst_dqs_en", {31'b0, dqs_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    wait_clk(4);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Seed 0x12 so the masked beat has a known prior value
    do_write(8'hA0, 8'hA0, 32'h10 + 32'h2, 5, 1, 32'h5A00_0000, 4'b0000);
    do_write(8'hA0, 8'hA0, 32'h10, 5, 4, 32'h1122_3344, 4'b0100);
    do_read("rd_basic", 8'h20, 32'h10, 5, 4, 32'h1122_5A44);

    do_write(8'hC0, 8'hC0, 32'h0, 0, 1, 32'h0700_0000, 4'b0000);
    do_read("mrr_rlc", 8'h40, 32'h0, 7, 1, 32'h0700_0000);
    do_read("mrr_wlc", 8'h40, 32'h4, 7, 1, 32'h0500_0000);
    do_read("rd_lat7", 8'h20, 32'h10, 7, 2, 32'h1122_0000);
    do_write(8'hC0, 8'hC0, 32'h0, 0, 1, 32'h0000_0000, 4'b0000);
    do_read("rd_lat0", 8'h20, 32'h10, 0, 4, 32'h1122_5A44);

    do_write(8'hA0, 8'hA1, 32'h10, 5, 4, 32'hDEAD_BEEF, 4'b0000);
    chk("err_mismatch", {31'b0, err}, 32'd1);
    do_read("rd_after_err", 8'h20, 32'h10, 0, 4, 32'h1122_5A44);
    chk("err_sticky", {31'b0, err}, 32'd1);

    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    chk("err_cleared", {31'b0, err}, 32'd0);
    do_write(8'h55, 8'h55, 32'h0, 0, 0, 32'h0, 4'b0000);
    chk("err_illegal", {31'b0, err}, 32'd1);

    start_txn();
    beat(8'hA0, 1'b0); beat(8'hA0, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    wait_clk(2);
    beat(8'h55, 1'b0); beat(8'h55, 1'b0);
    chk("midrst_ignored_err", {31'b0, err}, 32'd0);
    chk("midrst_ignored_busy", {31'b0, busy}, 32'd0);
    end_txn();

    start_txn();
    beat(8'hA0, 1'b0); beat(8'hA0, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0);
    end_txn();
    chk("ce_abort_busy", {31'b0, busy}, 32'd0);
    do_read("rd_after_abort", 8'h20, 32'h10, 5, 4, 32'h1122_5A44);

    do_write(8'hA0, 8'hA0, 32'hFFE, 5, 4, 32'hA1A2_A3A4, 4'b0000);
    do_read("rd_wrap", 8'h20, 32'hFFE, 5, 4, 32'hA1A2_A3A4);
    do_read("rd_wrap_next", 8'h20, WRAP_NEXT, 5, 2, 32'hA3A4_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
